// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave that gathers FRAME_WORDS words per chip-enable window and commits
// the frame to frame_data on ce release. A status/echo word stream is returned on sdo.
module spi_frame_receiver #(
    parameter int unsigned WORD_BITS   = 8,
    parameter int unsigned FRAME_WORDS = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic                             HSOSC_clk,
    input  logic                             reset,
    input  logic                             sck,
    input  logic                             sdi,
    output logic                             sdo,
    input  logic                             ce,
    output logic [WORD_BITS*FRAME_WORDS-1:0] frame_data,
    output logic                             frame_valid,
    input  logic                             frame_ack,
    output logic                             frame_error,
    output logic                             overrun
);

    localparam int unsigned BCW     = $clog2(WORD_BITS);
    localparam int unsigned WCW     = $clog2(FRAME_WORDS + 1);
    localparam int unsigned FW_BITS = WORD_BITS * FRAME_WORDS;

    typedef enum logic [1:0] {StWaitIdle, StIdle, StRecv, StEval} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_sdi_sync, r_ce_sync;
    logic                   r_sck_d, r_ce_d;

    state_t                 r_state;
    logic [BCW-1:0]         r_bit_cnt;
    logic [WCW-1:0]         r_word_cnt;
    logic                   r_extra;
    logic [WORD_BITS-1:0]   r_shift;
    logic [WORD_BITS-1:0]   r_last_word;
    logic [FW_BITS-1:0]     r_buf;
    logic [WORD_BITS-1:0]   r_tx;
    logic [BCW-1:0]         r_tx_cnt;
    logic                   r_status_phase;
    logic                   r_sdo;
    logic [FW_BITS-1:0]     r_frame_data;
    logic                   r_frame_valid;
    logic                   r_frame_error;
    logic                   r_overrun;
    logic                   r_sticky_error;

    logic                   w_sck, w_sdi, w_ce;
    logic                   w_sck_rise, w_sck_fall, w_ce_rise, w_ce_fall;
    logic [WORD_BITS-1:0]   w_word_next;
    logic [WORD_BITS-1:0]   w_tx_shift;
    logic [WORD_BITS-1:0]   w_status;
    logic                   w_tx_out;
    logic                   w_word_done;
    logic                   w_frame_full;
    logic                   w_complete;

    // ce chain resets high so a transaction already running at reset release
    // keeps the FSM parked in StWaitIdle until the pin really goes low.
    always_ff @(posedge HSOSC_clk or posedge reset) begin
        if (reset) begin
            r_sck_sync <= '0;
            r_sdi_sync <= '0;
            r_ce_sync  <= '1;
            r_sck_d    <= 1'b0;
            r_ce_d     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_ce_sync  <= {r_ce_sync[SYNC_STAGES-2:0], ce};
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
            r_ce_d     <= r_ce_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_ce       = r_ce_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_ce_rise  = w_ce & ~r_ce_d;
    assign w_ce_fall  = ~w_ce & r_ce_d;

    assign w_word_next  = MSB_FIRST ? {r_shift[WORD_BITS-2:0], w_sdi}
                                    : {w_sdi, r_shift[WORD_BITS-1:1]};
    assign w_tx_out     = MSB_FIRST ? r_tx[WORD_BITS-1] : r_tx[0];
    assign w_tx_shift   = MSB_FIRST ? {r_tx[WORD_BITS-2:0], 1'b0}
                                    : {1'b0, r_tx[WORD_BITS-1:1]};
    assign w_word_done  = (r_bit_cnt == BCW'(WORD_BITS - 1));
    assign w_frame_full = (r_word_cnt == WCW'(FRAME_WORDS));
    assign w_complete   = w_frame_full && (r_bit_cnt == '0) && !r_extra;

    always_comb begin
        w_status              = '0;
        w_status[WORD_BITS-1] = r_frame_valid;
        w_status[WORD_BITS-2] = r_overrun;
        w_status[WORD_BITS-3] = r_sticky_error;
    end

    always_ff @(posedge HSOSC_clk or posedge reset) begin
        if (reset) begin
            r_state        <= StWaitIdle;
            r_bit_cnt      <= '0;
            r_word_cnt     <= '0;
            r_extra        <= 1'b0;
            r_shift        <= '0;
            r_last_word    <= '0;
            r_buf          <= '0;
            r_tx           <= '0;
            r_tx_cnt       <= '0;
            r_status_phase <= 1'b0;
            r_sdo          <= 1'b0;
            r_frame_data   <= '0;
            r_frame_valid  <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
            r_sticky_error <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_sdo         <= (r_state == StRecv) ? w_tx_out : 1'b0;
            if (r_frame_valid && frame_ack) begin
                r_frame_valid <= 1'b0;
            end

            case (r_state)
                StWaitIdle: begin
                    if (!w_ce) begin
                        r_state <= StIdle;
                    end
                end
                StIdle: begin
                    if (w_ce_rise) begin
                        r_bit_cnt      <= '0;
                        r_word_cnt     <= '0;
                        r_extra        <= 1'b0;
                        r_tx           <= w_status;
                        r_tx_cnt       <= '0;
                        r_status_phase <= 1'b1;
                        r_state        <= StRecv;
                    end
                end
                StRecv: begin
                    if (w_ce_fall) begin
                        r_state <= StEval;
                    end else begin
                        // Words past the frame still feed the echo path but never the buffer.
                        if (w_sck_rise) begin
                            r_shift <= w_word_next;
                            if (w_frame_full) begin
                                r_extra <= 1'b1;
                            end
                            if (w_word_done) begin
                                r_bit_cnt   <= '0;
                                r_last_word <= w_word_next;
                                if (!w_frame_full) begin
                                    for (int unsigned i = 0; i < FRAME_WORDS; i++) begin
                                        if (r_word_cnt == WCW'(i)) begin
                                            r_buf[i*WORD_BITS +: WORD_BITS] <= w_word_next;
                                        end
                                    end
                                    r_word_cnt <= r_word_cnt + 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        if (w_sck_fall) begin
                            if (r_tx_cnt == BCW'(WORD_BITS - 1)) begin
                                r_tx           <= r_last_word;
                                r_tx_cnt       <= '0;
                                r_status_phase <= 1'b0;
                                if (r_status_phase) begin
                                    r_overrun      <= 1'b0;
                                    r_sticky_error <= 1'b0;
                                end
                            end else begin
                                r_tx     <= w_tx_shift;
                                r_tx_cnt <= r_tx_cnt + 1'b1;
                            end
                        end
                    end
                end
                StEval: begin
                    if (w_complete) begin
                        if (!r_frame_valid || frame_ack) begin
                            r_frame_data  <= r_buf;
                            r_frame_valid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_frame_error  <= 1'b1;
                        r_sticky_error <= 1'b1;
                    end
                    r_state <= StIdle;
                end
                default: r_state <= StWaitIdle;
            endcase
        end
    end

    assign sdo         = r_sdo;
    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: hand-derived vector table, corner sequences, and
// random transactions checked against a transaction-level model.
module tb_spi_frame_receiver;

    localparam int W    = 8;
    localparam int FW   = 4;
    localparam int S    = 2;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0, sdi = 1'b0, ce = 1'b0, frame_ack = 1'b0;
    logic        sdo, fv, fe, ovr;
    logic [31:0] fd;
    logic        sdo2, fv2, fe2, ovr2;
    logic [7:0]  fd2;

    always #5 clk = ~clk;

    spi_frame_receiver #(.WORD_BITS(W), .FRAME_WORDS(FW), .SYNC_STAGES(S), .MSB_FIRST(1'b1)) dut (
        .HSOSC_clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .sdo(sdo), .ce(ce),
        .frame_data(fd), .frame_valid(fv), .frame_ack(frame_ack), .frame_error(fe),
        .overrun(ovr)
    );

    spi_frame_receiver #(.WORD_BITS(W), .FRAME_WORDS(1), .SYNC_STAGES(S), .MSB_FIRST(1'b0)) dut2 (
        .HSOSC_clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .sdo(sdo2), .ce(ce),
        .frame_data(fd2), .frame_valid(fv2), .frame_ack(frame_ack), .frame_error(fe2),
        .overrun(ovr2)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_b [0:7];
    logic [7:0]  cap1 [0:7];
    logic [7:0]  cap2 [0:7];

    // Transaction-level model of the frame-side state
    logic        m_valid = 1'b0, m_ovr = 1'b0, m_sticky = 1'b0;
    logic [31:0] m_data = '0;

    // Results of the last do_txn
    logic [7:0]  r_status;
    logic        r_valid, r_err, r_ovr;
    logic [31:0] r_data;

    typedef struct {
        logic [39:0] bytes;
        int          nbits;
        bit          ack_commit;
        bit          ack_after;
        logic [7:0]  st;
        logic        valid;
        logic [31:0] data;
        logic        err;
        logic        ovr;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            sdi = tx_b[i/8][7-(i%8)];
            wait_clks(HALF);
            cap1[i/8][7-(i%8)] = sdo;
            cap2[i/8][i%8]     = sdo2;
            sck = 1'b1;
            wait_clks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic ce_begin();
        for (int i = 0; i < 8; i++) begin
            cap1[i] = '0;
            cap2[i] = '0;
        end
        ce = 1'b1;
        wait_clks(8);
    endtask

    task automatic ce_end();
        wait_clks(HALF);
        ce = 1'b0;
    endtask

    task automatic do_txn(input int nbits, input bit ack_commit, input bit ack_after,
                          input bit chk_model);
        logic [7:0]  exp_status;
        logic        exp_err, old_valid, complete;
        logic [31:0] frame;
        exp_status = {m_valid, m_ovr, m_sticky, 5'b0};
        old_valid  = m_valid;
        frame      = {tx_b[3], tx_b[2], tx_b[1], tx_b[0]};
        complete   = (nbits == W * FW);
        if (nbits >= W) begin
            m_ovr    = 1'b0;
            m_sticky = 1'b0;
        end
        exp_err = !complete;
        if (complete) begin
            if (!m_valid || ack_commit) begin
                m_data  = frame;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            m_sticky = 1'b1;
            if (ack_commit) m_valid = 1'b0;
        end

        ce_begin();
        send_bits(0, nbits);
        ce_end();
        wait_clks(S + 1);
        chk("valid_before_commit", fv, old_valid);
        chk("err_before_commit", fe, 1'b0);
        if (ack_commit) frame_ack = 1'b1;
        wait_clks(1);
        frame_ack = 1'b0;
        r_status = cap1[0];
        r_valid  = fv;
        r_data   = fd;
        r_err    = fe;
        r_ovr    = ovr;
        wait_clks(1);
        chk("err_single_cycle", fe, 1'b0);
        for (int k = 1; k < nbits / W; k++) chk("sdo_echo", cap1[k], tx_b[k-1]);
        if (chk_model) begin
            chk("model_status", r_status, exp_status);
            chk("model_valid", r_valid, m_valid);
            chk("model_data", r_data, m_data);
            chk("model_err", r_err, exp_err);
            chk("model_overrun", r_ovr, m_ovr);
        end
        if (ack_after) begin
            frame_ack = 1'b1;
            wait_clks(1);
            frame_ack = 1'b0;
            m_valid = 1'b0;
            chk("ack_clears_valid", fv, 1'b0);
        end
        wait_clks(3);
    endtask

    initial begin
        logic seen_valid, seen_err;
        int   r;

        tbl[0] = '{40'h00_44332211, 32, 1'b0, 1'b1, 8'h00, 1'b1, 32'h44332211, 1'b0, 1'b0};
        tbl[1] = '{40'h00_00030201, 24, 1'b0, 1'b0, 8'h00, 1'b0, 32'h44332211, 1'b1, 1'b0};
        tbl[2] = '{40'hE0_88776655, 35, 1'b0, 1'b0, 8'h20, 1'b0, 32'h44332211, 1'b1, 1'b0};
        tbl[3] = '{40'h00_A4A3A2A1, 32, 1'b0, 1'b0, 8'h20, 1'b1, 32'hA4A3A2A1, 1'b0, 1'b0};
        tbl[4] = '{40'h00_B4B3B2B1, 32, 1'b0, 1'b0, 8'h80, 1'b1, 32'hA4A3A2A1, 1'b0, 1'b1};
        tbl[5] = '{40'h00_C4C3C2C1, 32, 1'b1, 1'b0, 8'hC0, 1'b1, 32'hC4C3C2C1, 1'b0, 1'b0};
        tbl[6] = '{40'h00_D4D3D2D1, 32, 1'b0, 1'b1, 8'h80, 1'b1, 32'hC4C3C2C1, 1'b0, 1'b1};
        tbl[7] = '{40'h00_E4E3E2E1, 32, 1'b0, 1'b1, 8'h40, 1'b1, 32'hE4E3E2E1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) tx_b[i] = '0;

        wait_clks(3);
        chk("rst_sdo", sdo, 1'b0);
        chk("rst_valid", fv, 1'b0);
        chk("rst_data", fd, 32'h0);
        chk("rst_err", fe, 1'b0);
        chk("rst_overrun", ovr, 1'b0);
        chk("rst_data2", fd2, 8'h0);
        reset = 1'b0;
        wait_clks(10);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) tx_b[j] = (j < 5) ? tbl[i].bytes[8*j +: 8] : 8'h00;
            do_txn(tbl[i].nbits, tbl[i].ack_commit, tbl[i].ack_after, 1'b0);
            chk("tbl_status", r_status, tbl[i].st);
            chk("tbl_valid", r_valid, tbl[i].valid);
            chk("tbl_data", r_data, tbl[i].data);
            chk("tbl_err", r_err, tbl[i].err);
            chk("tbl_overrun", r_ovr, tbl[i].ovr);
        end

        // Reset in the middle of a transaction; the tail must be ignored.
        for (int j = 0; j < 8; j++) tx_b[j] = 8'(j + 1);
        ce_begin();
        send_bits(0, 16);
        wait_clks(2);
        reset = 1'b1;
        #1;
        chk("midrst_sdo", sdo, 1'b0);
        chk("midrst_valid", fv, 1'b0);
        chk("midrst_data", fd, 32'h0);
        chk("midrst_overrun", ovr, 1'b0);
        wait_clks(3);
        reset = 1'b0;
        m_valid = 1'b0; m_ovr = 1'b0; m_sticky = 1'b0; m_data = '0;
        send_bits(16, 16);
        ce_end();
        seen_valid = 1'b0;
        seen_err   = 1'b0;
        for (int c = 0; c < S + 6; c++) begin
            wait_clks(1);
            seen_valid |= fv;
            seen_err   |= fe;
        end
        chk("midrst_no_commit", seen_valid, 1'b0);
        chk("midrst_no_err", seen_err, 1'b0);
        tx_b[0] = 8'h0F; tx_b[1] = 8'h1E; tx_b[2] = 8'h2D; tx_b[3] = 8'h3C;
        do_txn(32, 1'b0, 1'b1, 1'b1);

        // One-word frame on the LSB-first instance; the MSB-first one flags a length error.
        tx_b[0] = 8'h96;
        do_txn(8, 1'b0, 1'b0, 1'b1);
        chk("lsb_fw1_valid", fv2, 1'b1);
        chk("lsb_fw1_data", fd2, rev8(8'h96));

        tx_b[0] = 8'hA5; tx_b[1] = 8'h5A; tx_b[2] = 8'h12; tx_b[3] = 8'h34;
        do_txn(32, 1'b1, 1'b1, 1'b1);
        chk("lsb_echo1", cap2[1], rev8(8'hA5));
        chk("lsb_echo2", cap2[2], rev8(8'h5A));
        chk("lsb_echo3", cap2[3], rev8(8'h12));

        for (int t = 0; t < 40; t++) begin
            for (int j = 0; j < 8; j++) tx_b[j] = 8'($urandom);
            r = $urandom_range(0, 9);
            do_txn((r <= 5) ? 32 : (r == 6) ? 24 : (r == 7) ? 35 : (r == 8) ? 40 : 8,
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Parametrised SPI slave receiver that assembles a multi-word game frame from the MCU, replacing the single-byte `spi` plus `~ce` frame-ready scheme. All SPI pins are synchronised into the `HSOSC_clk` domain, and the bits are shifted into a frame buffer. On chip-enable release, a complete frame is committed atomically to `frame_data`. A valid/ack handshake toward the state manager handles delivery, with length-error and overrun detection. It sits between the SPI pins and `state_manager`/`game_encoder`.

## Interface
- `WORD_BITS`, default 8: bits per SPI word.
- `FRAME_WORDS`, default 4: words per complete frame (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops on `sck`, `sdi`, `ce` (≥2).
- `MSB_FIRST`, default 1: 1 means the first received bit lands in word bit `WORD_BITS-1`; 0 means bit 0.
- `HSOSC_clk`, in, 1: system clock. `sck` must be ≤ `HSOSC_clk`/8.
- `reset`, in, 1: reset. **Asynchronous, active-high.**
- `sck`, in, 1: SPI clock, mode 0 (idle low, sample on rising edge).
- `sdi`, in, 1: SPI data from master.
- `sdo`, out, 1: SPI data to master, changed after `sck` falling edges.
- `ce`, in, 1: chip enable. Active-high; high for the whole transaction.
- `frame_data`, out, `WORD_BITS*FRAME_WORDS`: last committed frame. Word 0 (first received) is in the LSBs.
- `frame_valid`, out, 1: committed frame not yet acknowledged.
- `frame_ack`, in, 1: consumer accepts the frame. Sampled only while `frame_valid`=1.
- `frame_error`, out, 1: one-cycle pulse when a transaction is discarded for wrong length.
- `overrun`, out, 1: sticky. A complete frame was dropped because `frame_valid` was still high.

## Operation
- Synchronisation: `sck`, `sdi`, `ce` each pass through `SYNC_STAGES` flops. Edges are detected from the last stage against one extra delay flop.
- FSM states:
  - WAIT_IDLE: reset state. Transitions to IDLE when synced `ce`=0. A transaction already in progress at reset release is therefore ignored entirely.
  - IDLE: on synced `ce` rising edge, clear `bit_cnt` and `word_cnt`, load the status word into the sdo shifter, go to RECV.
  - RECV:
    - Each synced `sck` rising edge shifts `sdi` into the word shifter and increments `bit_cnt`.
    - When `bit_cnt` reaches `WORD_BITS`, write the word to `buf[word_cnt]`, clear `bit_cnt`, increment `word_cnt`.
    - On synced `ce` falling edge, evaluate the transaction and go to IDLE.
- Word overflow: `word_cnt` saturates at `FRAME_WORDS`. Further bits are counted into an `extra` flag and not written.
- Evaluation at `ce` fall:
  - Complete means `word_cnt`==`FRAME_WORDS`, `bit_cnt`==0, and `extra`=0.
  - Anything else pulses `frame_error` for one cycle and leaves `frame_data`/`frame_valid` unchanged.
  - Complete with `frame_valid`=0, or with `frame_ack`=1 in the same cycle: copy `buf` to `frame_data`, `frame_valid`=1.
  - Complete with `frame_valid`=1 and no ack: drop the frame, keep old `frame_data`, set `overrun`.
- Handshake: `frame_valid`=1 and `frame_ack`=1 clears `frame_valid` next cycle, unless a commit occurs in the same cycle (then it stays 1 with new data).
- `sdo`:
  - First word of each transaction is the status word `{frame_valid, overrun, sticky_error, 0…}`, MSB/LSB order per `MSB_FIRST`. `WORD_BITS` must be ≥3.
  - Each later word echoes the previously received word of this transaction.
  - The shifter advances on synced `sck` falling edge.
  - `sdo`=0 outside RECV.
- `sticky_error` is set with each `frame_error` pulse. `overrun` and `sticky_error` clear when the status word's last bit has been shifted out.

## Timing
- Reset values:
  - `sdo`=0, `frame_data`=0, `frame_valid`=0, `frame_error`=0, `overrun`=0.
  - State WAIT_IDLE, all counters and buffers 0.
- Pin-to-detect latency: `SYNC_STAGES`+1 `HSOSC_clk` cycles for each of `sck`/`ce` edges. `sdi` uses equal-depth sync, so data and clock stay aligned.
- Commit: `frame_valid` rises and `frame_data` updates on the same edge, 1 cycle after synced `ce` fall detection. This is `SYNC_STAGES`+2 cycles after the pin fall.
- `frame_ack` to `frame_valid` low: 1 cycle.
- `sdo` changes `SYNC_STAGES`+2 cycles after the `sck` pin falls. This is valid before the next rising edge given the `sck` ≤ clk/8 rule.
- Reset asserted mid-transaction: all outputs return to reset values immediately (async). The rest of that transaction is ignored via WAIT_IDLE.

## Test plan
- Reset, then `ce` high, send bytes 0x11,0x22,0x33,0x44, `ce` low → `frame_valid`=1 and `frame_data`=0x44332211 at SYNC_STAGES+2 cycles after `ce` fall; `frame_ack` pulse → `frame_valid`=0 next cycle.
- Send 3 bytes (or 4 bytes + 3 bits), `ce` low → single-cycle `frame_error`, `frame_valid` stays 0, `frame_data` unchanged; next transaction's first `sdo` word = 0x20.
- Two complete frames A then B without ack → `frame_data`=A, `overrun`=1; then a transaction shifting out status 0xC0 clears `overrun`.
- Frame B commit coinciding with `frame_ack` of A → `frame_valid` stays 1, `frame_data`=B, `overrun`=0.
- Assert `reset` after 2 bytes of a transaction, release while `ce` still high, finish 2 more bytes → no commit, no `frame_error`; next full frame commits normally.
- `sdo` echo: send 0xA5,0x5A,… → second word on `sdo` reads 0xA5, third reads 0x5A; repeat with `MSB_FIRST`=0 and `FRAME_WORDS`=1.
